// File: rtl/pack_rq0.sv
// pack_rq0 - serializing packer for Rq0 polynomials (NTRU-HRSS encode side).
//
// Accepts N coefficients of LOGQ bits, coefficient 0 first, and packs the
// first N-1 of them into a little-endian byte stream: coefficient i bit j
// lands on stream bit LOGQ*i + j, byte k carries stream bits 8k..8k+7 with
// bit 8k at out_byte[0]. The last coefficient is accepted and dropped
// because the unpacker rebuilds it from the zero-sum property. The final
// byte is zero-padded in its upper bits.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. A source holds its valid and payload stable until the
// transfer; ready may rise and fall freely. Neither in_ready nor any output
// depends combinationally on in_valid or out_ready.
//
// Ports:
//   clk         rising-edge clock
//   rst         asynchronous, active-high reset (drops any partial frame)
//   in_coef     coefficient, already reduced mod q
//   in_valid    in_coef is valid
//   in_ready    coefficient accepted this cycle
//   out_byte    packed byte (0x00 whenever out_valid is low)
//   out_valid   out_byte is valid
//   out_ready   downstream accepts out_byte
//   out_last    out_byte is the final byte of the frame
//   done        one-cycle pulse after the frame has been fully emitted
//   dbg_state_o current FSM state (0 PACK, 1 DROP, 2 FLUSH, 3 END)

module pack_rq0 #(
  parameter int N    = 701,
  parameter int LOGQ = 13
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [LOGQ-1:0] in_coef,
  input  logic            in_valid,
  output logic            in_ready,
  output logic [7:0]      out_byte,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            out_last,
  output logic            done,
  output logic [1:0]      dbg_state_o
);

  // Bit buffer holds at most 7 leftover bits plus one fresh coefficient.
  localparam int BW = LOGQ + 7;
  localparam int KW = $clog2(BW + 1);
  localparam int CW = $clog2(N);

  typedef enum logic [1:0] {
    ST_PACK  = 2'd0,
    ST_DROP  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_END   = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [BW-1:0]   bitbuf_q, bitbuf_d;
  logic [KW-1:0]   bitcnt_q, bitcnt_d;
  logic [CW-1:0]   cidx_q, cidx_d;

  logic            has_byte;
  logic            byte_hs;
  logic            in_hs;
  logic [7:0]      low_mask;

  assign has_byte    = (bitcnt_q >= KW'(8));
  assign byte_hs     = out_valid & out_ready;
  assign in_hs       = in_valid & in_ready;
  assign dbg_state_o = state_q;

  // Mask of the valid low bits of the final, partially filled byte.
  always_comb begin
    low_mask = 8'h00;
    for (int j = 0; j < 8; j++) begin
      low_mask[j] = (KW'(j) < bitcnt_q);
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_PACK;
      bitbuf_q <= '0;
      bitcnt_q <= '0;
      cidx_q   <= '0;
    end else begin
      state_q  <= state_d;
      bitbuf_q <= bitbuf_d;
      bitcnt_q <= bitcnt_d;
      cidx_q   <= cidx_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    bitbuf_d = bitbuf_q;
    bitcnt_d = bitcnt_q;
    cidx_d   = cidx_q;
    case (state_q)
      ST_PACK: begin
        if (byte_hs) begin
          bitbuf_d = bitbuf_q >> 8;
          bitcnt_d = bitcnt_q - KW'(8);
        end else if (in_hs) begin
          // Bits at and above bitcnt are always zero (shifts fill with
          // zeros and every clear zeroes the whole buffer), so OR-in works.
          bitbuf_d = bitbuf_q | (BW'(in_coef) << bitcnt_q);
          bitcnt_d = bitcnt_q + KW'(LOGQ);
          cidx_d   = cidx_q + CW'(1);
          if (cidx_q == CW'(N - 2)) begin
            state_d = ST_DROP;
          end
        end
      end
      ST_DROP: begin
        if (byte_hs) begin
          bitbuf_d = bitbuf_q >> 8;
          bitcnt_d = bitcnt_q - KW'(8);
        end else if (in_hs) begin
          // Last coefficient: consumed but not stored.
          state_d = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        if (bitcnt_q == '0) begin
          state_d = ST_END;
        end else if (byte_hs) begin
          bitbuf_d = '0;
          bitcnt_d = '0;
          state_d  = ST_END;
        end
      end
      ST_END: begin
        bitbuf_d = '0;
        bitcnt_d = '0;
        cidx_d   = '0;
        state_d  = ST_PACK;
      end
      default: state_d = ST_PACK;
    endcase
  end

  // Outputs, decoded from registers only (rst gates in_ready).
  always_comb begin
    in_ready  = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    out_byte  = 8'h00;
    done      = 1'b0;
    case (state_q)
      ST_PACK: begin
        in_ready  = ~rst & ~has_byte;
        out_valid = has_byte;
        if (has_byte) out_byte = bitbuf_q[7:0];
      end
      ST_DROP: begin
        in_ready  = ~rst & ~has_byte;
        out_valid = has_byte;
        if (has_byte) out_byte = bitbuf_q[7:0];
        // Byte-aligned frame: the byte that empties the buffer is the last.
        out_last  = (bitcnt_q == KW'(8));
      end
      ST_FLUSH: begin
        out_valid = (bitcnt_q != '0);
        out_last  = (bitcnt_q != '0);
        if (bitcnt_q != '0) out_byte = bitbuf_q[7:0] & low_mask;
      end
      ST_END: begin
        done = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_pack_rq0.sv
// Bench for pack_rq0: three instances (N=4, N=9, N=701) fed from a common
// clock. Expected bytes come from hand-derived tables or from a bit-level
// reference model of the packing rule.

module tb_pack_rq0;

  localparam int NI = 3;
  localparam int NV = 4;
  localparam int TO = 400;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [12:0] in_coef   [NI];
  logic        in_valid  [NI];
  logic        in_ready  [NI];
  logic [7:0]  out_byte  [NI];
  logic        out_valid [NI];
  logic        out_ready [NI];
  logic        out_last  [NI];
  logic        done      [NI];
  logic [1:0]  dbg_state [NI];

  pack_rq0 #(.N(4), .LOGQ(13)) u_n4 (
    .clk(clk), .rst(rst), .in_coef(in_coef[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .out_byte(out_byte[0]), .out_valid(out_valid[0]),
    .out_ready(out_ready[0]), .out_last(out_last[0]), .done(done[0]),
    .dbg_state_o(dbg_state[0]));

  pack_rq0 #(.N(9), .LOGQ(13)) u_n9 (
    .clk(clk), .rst(rst), .in_coef(in_coef[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .out_byte(out_byte[1]), .out_valid(out_valid[1]),
    .out_ready(out_ready[1]), .out_last(out_last[1]), .done(done[1]),
    .dbg_state_o(dbg_state[1]));

  pack_rq0 #(.N(701), .LOGQ(13)) u_n701 (
    .clk(clk), .rst(rst), .in_coef(in_coef[2]), .in_valid(in_valid[2]),
    .in_ready(in_ready[2]), .out_byte(out_byte[2]), .out_valid(out_valid[2]),
    .out_ready(out_ready[2]), .out_last(out_last[2]), .done(done[2]),
    .dbg_state_o(dbg_state[2]));

  // ---------------- scoreboard state ----------------
  int          n_cmp;
  int          n_err;
  int          cyc;
  logic [8:0]  exp_q [$];          // {last, byte}
  logic [8:0]  got_q [NI][$];
  logic [12:0] coef_q [$];
  int          done_cnt    [NI];
  int          done_cyc    [NI];
  int          last_hs_cyc [NI];
  int          ready_mode  [NI];   // 0 low, 1 high, 2 random
  bit          stall_prev  [NI];
  logic [9:0]  held        [NI];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_err++;
    $display("FAIL %s: timed out after %0d cycles", name, TO);
  endtask

  // out_ready driver (applied 2 time units after each rising edge).
  always @(posedge clk) begin
    #2;
    for (int d = 0; d < NI; d++) begin
      case (ready_mode[d])
        0:       out_ready[d] = 1'b0;
        1:       out_ready[d] = 1'b1;
        default: out_ready[d] = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Output monitor: values at the falling edge are those the next rising
  // edge will see.
  always @(negedge clk) begin
    cyc++;
    for (int d = 0; d < NI; d++) begin
      if (rst) begin
        stall_prev[d] = 1'b0;
      end else begin
        if (stall_prev[d])
          check($sformatf("stall_hold[%0d]", d),
                32'({out_valid[d], out_last[d], out_byte[d]}), 32'(held[d]));
        if (out_valid[d])
          check($sformatf("ready_excl[%0d]", d), 32'(in_ready[d]), 32'd0);
        if (out_valid[d] && out_ready[d]) begin
          got_q[d].push_back({out_last[d], out_byte[d]});
          if (out_last[d]) last_hs_cyc[d] = cyc;
        end
        if (done[d]) begin
          done_cnt[d]++;
          done_cyc[d] = cyc;
        end
        stall_prev[d] = out_valid[d] && !out_ready[d];
        held[d]       = {1'b1, out_last[d], out_byte[d]};
      end
    end
  end

  // ---------------- reference model ----------------
  // coef_q holds one frame of n coefficients; appends its bytes to exp_q.
  function automatic void model_frame(input int n);
    int total;
    int nb;
    total = (n - 1) * 13;
    nb    = (total + 7) / 8;
    for (int k = 0; k < nb; k++) begin
      logic [7:0]  b;
      logic [12:0] c;
      int          p;
      b = 8'h00;
      for (int j = 0; j < 8; j++) begin
        p = 8 * k + j;
        if (p < total) begin
          c    = coef_q[p / 13];
          b[j] = c[p % 13];
        end
      end
      exp_q.push_back({(k == nb - 1), b});
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Entered and left at 1 time unit after a rising edge.
  task automatic send_coefs(input int d, input bit gaps, input bit hold);
    bit hs;
    int w;
    for (int i = 0; i < coef_q.size(); i++) begin
      if (gaps && $urandom_range(0, 2) == 0) begin
        in_valid[d] = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      in_valid[d] = 1'b1;
      in_coef[d]  = coef_q[i];
      hs = 1'b0;
      w  = 0;
      while (!hs && w < TO) begin
        @(negedge clk);
        hs = in_ready[d];
        @(posedge clk);
        #1;
        w++;
      end
      if (!hs) begin
        timeout($sformatf("in_handshake[%0d] coef %0d", d, i));
        in_valid[d] = 1'b0;
        return;
      end
    end
    if (!hold) in_valid[d] = 1'b0;
  endtask

  task automatic wait_done(input int d, input int target, input string name);
    int w;
    w = 0;
    while (done_cnt[d] < target && w < TO) begin
      @(posedge clk);
      #1;
      w++;
    end
    if (done_cnt[d] < target) timeout({name, ".done"});
    repeat (3) @(posedge clk);
    #1;
    check({name, ".done_count"}, 32'(done_cnt[d]), 32'(target));
  endtask

  task automatic compare_frame(input int d, input string name);
    int ng;
    ng = got_q[d].size();
    check({name, ".count"}, 32'(ng), 32'(exp_q.size()));
    for (int k = 0; k < exp_q.size(); k++) begin
      if (k < ng)
        check($sformatf("%s.byte%0d", name, k), 32'(got_q[d][k]), 32'(exp_q[k]));
    end
    exp_q.delete();
    got_q[d].delete();
  endtask

  // ---------------- vector table (N=4) ----------------
  typedef struct packed {
    logic [3:0][12:0] c;
    logic [4:0][7:0]  b;
  } vec_t;

  function automatic vec_t mk(input logic [12:0] c0, c1, c2, c3,
                              input logic [7:0] b0, b1, b2, b3, b4);
    vec_t v;
    v.c[0] = c0; v.c[1] = c1; v.c[2] = c2; v.c[3] = c3;
    v.b[0] = b0; v.b[1] = b1; v.b[2] = b2; v.b[3] = b3; v.b[4] = b4;
    return v;
  endfunction

  vec_t vt [NV];
  int   tgt0;

  task automatic load_vec(input int v);
    for (int i = 0; i < 4; i++) coef_q.push_back(vt[v].c[i]);
    for (int k = 0; k < 5; k++) exp_q.push_back({(k == 4), vt[v].b[k]});
  endtask

  task automatic apply_vec(input int v, input string name);
    coef_q.delete();
    load_vec(v);
    send_coefs(0, 1'b0, 1'b0);
    tgt0++;
    wait_done(0, tgt0, name);
    check({name, ".done_latency"}, 32'(done_cyc[0] - last_hs_cyc[0]), 32'd1);
    compare_frame(0, name);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    tgt0  = 0;
    rst   = 1'b1;
    for (int d = 0; d < NI; d++) begin
      in_valid[d]    = 1'b0;
      in_coef[d]     = '0;
      out_ready[d]   = 1'b0;
      ready_mode[d]  = 0;
      done_cnt[d]    = 0;
      done_cyc[d]    = 0;
      last_hs_cyc[d] = 0;
      stall_prev[d]  = 1'b0;
      held[d]        = '0;
    end

    vt[0] = mk(13'h1FFF, 13'h0000, 13'h1FFF, 13'h1234, 8'hFF, 8'h1F, 8'h00, 8'hFC, 8'h7F);
    vt[1] = mk(13'h0001, 13'h0002, 13'h0004, 13'h0FFF, 8'h01, 8'h40, 8'h00, 8'h10, 8'h00);
    vt[2] = mk(13'h1FFF, 13'h1FFF, 13'h1FFF, 13'h1ABC, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h7F);
    vt[3] = mk(13'h0AAA, 13'h1555, 13'h0F0F, 13'h1FFF, 8'hAA, 8'hAA, 8'hAA, 8'h3E, 8'h3C);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) begin
      check($sformatf("reset.out_valid[%0d]", d), 32'(out_valid[d]), 32'd0);
      check($sformatf("reset.out_last[%0d]", d),  32'(out_last[d]),  32'd0);
      check($sformatf("reset.done[%0d]", d),      32'(done[d]),      32'd0);
      check($sformatf("reset.out_byte[%0d]", d),  32'(out_byte[d]),  32'd0);
      check($sformatf("reset.in_ready[%0d]", d),  32'(in_ready[d]),  32'd0);
      check($sformatf("reset.state[%0d]", d),     32'(dbg_state[d]), 32'd0);
    end
    rst = 1'b0;
    #1;
    for (int d = 0; d < NI; d++)
      check($sformatf("post_reset.in_ready[%0d]", d), 32'(in_ready[d]), 32'd1);
    @(posedge clk);
    #1;
    for (int d = 0; d < NI; d++) ready_mode[d] = 1;

    // Table-driven N=4 frames, out_ready held high.
    for (int v = 0; v < NV; v++) apply_vec(v, $sformatf("vec%0d", v));

    // Back-to-back N=4 frames with in_valid held high throughout.
    coef_q.delete();
    load_vec(1);
    load_vec(3);
    send_coefs(0, 1'b0, 1'b0);
    tgt0 += 2;
    wait_done(0, tgt0, "b2b");
    compare_frame(0, "b2b");

    // Randomized N=4 frames against the model, with throttling.
    ready_mode[0] = 2;
    for (int f = 0; f < 6; f++) begin
      coef_q.delete();
      for (int i = 0; i < 4; i++) coef_q.push_back(13'($urandom_range(0, 8191)));
      model_frame(4);
      send_coefs(0, 1'b1, 1'b0);
      tgt0++;
      wait_done(0, tgt0, $sformatf("rnd4_%0d", f));
      check($sformatf("rnd4_%0d.done_latency", f),
            32'(done_cyc[0] - last_hs_cyc[0]), 32'd1);
      compare_frame(0, $sformatf("rnd4_%0d", f));
    end

    // First-byte latency, then asynchronous reset mid-frame.
    ready_mode[0] = 0;
    @(posedge clk);
    #1;
    in_valid[0] = 1'b1;
    in_coef[0]  = 13'h1FFF;
    @(negedge clk);
    check("lat.in_ready", 32'(in_ready[0]), 32'd1);
    @(posedge clk);
    #1;
    in_valid[0] = 1'b0;
    @(negedge clk);
    check("lat.out_valid", 32'(out_valid[0]), 32'd1);
    check("lat.out_byte",  32'(out_byte[0]),  32'hFF);
    check("lat.in_ready_low", 32'(in_ready[0]), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    ready_mode[0] = 1;
    coef_q.delete();
    coef_q.push_back(13'h0155);
    send_coefs(0, 1'b0, 1'b0);
    ready_mode[0] = 0;
    #3;
    rst = 1'b1;
    #1;
    check("midrst.out_valid", 32'(out_valid[0]), 32'd0);
    check("midrst.in_ready",  32'(in_ready[0]),  32'd0);
    check("midrst.out_last",  32'(out_last[0]),  32'd0);
    check("midrst.out_byte",  32'(out_byte[0]),  32'd0);
    check("midrst.done",      32'(done[0]),      32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    got_q[0].delete();
    ready_mode[0] = 1;
    apply_vec(1, "after_rst");

    // N=9: byte-aligned frame, no padding byte.
    coef_q.delete();
    for (int i = 0; i < 8; i++) coef_q.push_back(13'h1FFF);
    coef_q.push_back(13'h0ABC);
    for (int k = 0; k < 13; k++) exp_q.push_back({(k == 12), 8'hFF});
    send_coefs(1, 1'b0, 1'b0);
    wait_done(1, 1, "n9_ones");
    compare_frame(1, "n9_ones");

    // N=9 random frame with throttling.
    ready_mode[1] = 2;
    coef_q.delete();
    for (int i = 0; i < 9; i++) coef_q.push_back(13'($urandom_range(0, 8191)));
    model_frame(9);
    send_coefs(1, 1'b1, 1'b0);
    wait_done(1, 2, "n9_rnd");
    compare_frame(1, "n9_rnd");

    // N=701 random frame with throttling on both sides.
    ready_mode[2] = 2;
    coef_q.delete();
    for (int i = 0; i < 701; i++) coef_q.push_back(13'($urandom_range(0, 8191)));
    model_frame(701);
    send_coefs(2, 1'b1, 1'b0);
    wait_done(2, 1, "n701");
    check("n701.byte_total", 32'(got_q[2].size()), 32'd1138);
    if (got_q[2].size() > 0)
      check("n701.pad_bits", 32'(got_q[2][got_q[2].size() - 1] & 9'h0F0), 32'd0);
    compare_frame(2, "n701");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
